div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Parametrised multi-cycle integer divider for the execute stage (RV64M DIV/DIVU/REM/REMU/*W).
//  Restoring algorithm; retires STEP quotient bits per cycle.
//  Signed and unsigned modes, plus half-width (word) mode with sign-extended results.
//  Valid/ready on both sides; pipeline flush aborts the operation in flight.
// PARAMETERS
//  WIDTH  64  operand/result width; even, >=8
//  STEP   1   quotient bits per cycle; 1, 2 or 4; must divide WIDTH/2
// PORTS
//  clk        in   1      clock, rising edge
//  resetn     in   1      reset, asynchronous, active-low
//  in_valid   in   1      operation request
//  in_ready   out  1      unit idle, can accept
//  a          in   WIDTH  dividend
//  b          in   WIDTH  divisor
//  is_signed  in   1      1: two's-complement operands and results
//  is_word    in   1      1: use a[WIDTH/2-1:0], b[WIDTH/2-1:0]; results sign-extended from bit WIDTH/2-1
//  flush      in   1      abort current operation
//  out_valid  out  1      quot/rem valid
//  out_ready  in   1      consumer takes result
//  quot       out  WIDTH  quotient
//  rem        out  WIDTH  remainder
// BEHAVIOUR
//  Reset (resetn low, async): state=IDLE; out_valid=0, quot=0, rem=0.
//   in_ready forced 0 while resetn low.
//  FSM: IDLE -> PREP -> ITER -> POST -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid && !flush -> latch a, b, is_signed, is_word; go to PREP.
//   PREP: special cases go straight to DONE:
//    b==0 -> quot=all ones, rem=a (word: sext of low half).
//    signed, a==MIN, b==-1 -> quot=MIN, rem=0 (MIN taken at the active width).
//    Otherwise: take magnitudes, clear partial remainder, load N = (is_word ? WIDTH/2 : WIDTH)/STEP; go to ITER.
//   ITER: STEP restoring steps per cycle, MSB first. Each step: rem = {rem, next dividend bit};
//    if rem>=|b| then rem -= |b| and the quotient bit is 1, else 0. Go to POST after N cycles.
//   POST: apply signs. quot negated if signs differ; rem takes the sign of the dividend.
//    Word mode: sign-extend both results from bit WIDTH/2-1, in both signed and unsigned mode.
//    Go to DONE.
//   DONE: out_valid=1; quot/rem stable until out_ready. out_ready -> IDLE; out_valid=0 next cycle.
//  Latency (accept edge to out_valid high): N+3 cycles; 2 cycles for special cases.
//   WIDTH=64, STEP=1: 67 cycles (full width), 35 cycles (word).
//  Throughput: one op in flight. in_ready is low in DONE, so a new op is accepted at the earliest
//   on the cycle after the result handshake.
//  flush: from any state, next edge -> IDLE with out_valid=0.
//   flush has priority over in_valid (no accept) and over out_ready.
//   The quot/rem registers need not be cleared on flush.
//  Internal arithmetic: partial remainder is WIDTH+1 bits so the compare/subtract cannot overflow.
//  Inputs a/b may change after acceptance without effect.
// CONFIGURATION
//  DIV_EARLY_EXIT_EN defined:
//   in PREP, if |a| < |b| (active width) -> quot=0, rem=a (sext in word mode); go to DONE (latency 2).
//  Not defined: such operands take the full iteration path; results are identical, only latency differs.
// TESTING
//  1 unsigned: a=100, b=7 -> quot=14, rem=2; out_valid exactly 67 cycles after accept (WIDTH=64, STEP=1).
//  2 signed: a=-7, b=2 -> quot=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1; also a=7, b=-2 -> quot=-3, rem=1.
//  3 b=0, a=0x1234 -> quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234, latency 2.
//    Signed a=0x8000_0000_0000_0000, b=-1 -> quot=a, rem=0.
//  4 word signed: a=0x0000_0000_8000_0000, b=0xFFFF_FFFF -> quot=0xFFFF_FFFF_8000_0000, rem=0.
//    Word unsigned: a=0xFFFF_FFFF, b=1 -> quot=0xFFFF_FFFF_FFFF_FFFF; latency 35.
//  5 flush asserted 10 cycles after accept -> IDLE next cycle, out_valid stays 0, in_ready=1.
//    A new op 9/3 then returns quot=3, rem=0.
//  6 out_ready held low 5 cycles in DONE -> quot/rem/out_valid stable, in_ready=0.
//    resetn pulsed low mid-ITER -> outputs 0 immediately.
//    Repeat test 1 with DIV_EARLY_EXIT_EN and STEP=2/4; check a=3, b=10 early exit.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: operand handshake, flush and result handshake.
// WIDTH must match the WIDTH of the div_unit instance it connects to.
interface div_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             is_word;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (
    output in_valid, a, b, is_signed, is_word, flush, out_ready,
    input  in_ready, out_valid, quot, rem
  );

  modport slave (
    input  in_valid, a, b, is_signed, is_word, flush, out_ready,
    output in_ready, out_valid, quot, rem
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider (RV64M DIV/DIVU/REM/REMU and *W forms), STEP quotient bits/cycle.
// Optional DIV_EARLY_EXIT_EN: finish in PREP when |a| < |b| at the active width.
module div_unit #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);
  localparam int HALF  = WIDTH / 2;
  localparam int NFULL = WIDTH / STEP;
  localparam int NWORD = HALF / STEP;
  localparam int CW    = $clog2(NFULL + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
    sext_half = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] zext_half(input logic [WIDTH-1:0] v);
    zext_half = {{HALF{1'b0}}, v[HALF-1:0]};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r;
  logic             signed_r, word_r;
  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic [WIDTH:0]   prem_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] a_act_s, b_act_s, mag_a_s, mag_b_s, min_s;
  logic             sign_a_s, sign_b_s, b_zero_s, ovf_s, early_s, special_s;
  logic [WIDTH:0]   prem_nx_s, cand_s;
  logic [WIDTH-1:0] dvd_nx_s, q_neg_s, r_neg_s, q_fin_s, r_fin_s;
  logic             in_ready_s, out_valid_nx_s;

  // Operand decode at the active width: sign, magnitude and special-case detection
  always_comb begin
    if (word_r) begin
      a_act_s = signed_r ? sext_half(a_r) : zext_half(a_r);
      b_act_s = signed_r ? sext_half(b_r) : zext_half(b_r);
      min_s   = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_act_s = a_r;
      b_act_s = b_r;
      min_s   = {1'b1, {(WIDTH-1){1'b0}}};
    end
    sign_a_s = signed_r & a_act_s[WIDTH-1];
    sign_b_s = signed_r & b_act_s[WIDTH-1];
    mag_a_s  = sign_a_s ? (~a_act_s + {{(WIDTH-1){1'b0}}, 1'b1}) : a_act_s;
    mag_b_s  = sign_b_s ? (~b_act_s + {{(WIDTH-1){1'b0}}, 1'b1}) : b_act_s;
    b_zero_s = (b_act_s == {WIDTH{1'b0}});
    ovf_s    = signed_r && (a_act_s == min_s) && (b_act_s == {WIDTH{1'b1}});
`ifdef DIV_EARLY_EXIT_EN
    early_s  = (mag_a_s < mag_b_s);
`else
    early_s  = 1'b0;
`endif
    special_s = b_zero_s | ovf_s | early_s;
  end

  // STEP restoring steps, MSB first; quotient bits shift in at the bottom of dvd
  always_comb begin
    prem_nx_s = prem_r;
    dvd_nx_s  = dvd_r;
    cand_s    = prem_r;
    for (int i = 0; i < STEP; i++) begin
      cand_s = {prem_nx_s[WIDTH-1:0], dvd_nx_s[WIDTH-1]};
      if (cand_s >= {1'b0, dvs_r}) begin
        prem_nx_s = cand_s - {1'b0, dvs_r};
        dvd_nx_s  = {dvd_nx_s[WIDTH-2:0], 1'b1};
      end else begin
        prem_nx_s = cand_s;
        dvd_nx_s  = {dvd_nx_s[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the magnitudes; word results always sign-extend from bit HALF-1
  always_comb begin
    q_neg_s = (sign_a_s ^ sign_b_s) ? (~dvd_r + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_r;
    r_neg_s = sign_a_s ? (~prem_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : prem_r[WIDTH-1:0];
    if (word_r) begin
      q_fin_s = sext_half(q_neg_s);
      r_fin_s = sext_half(r_neg_s);
    end else begin
      q_fin_s = q_neg_s;
      r_fin_s = r_neg_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush wins over every other condition
  always_comb begin
    state_s = state_r;
    if (bus.flush) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_s = bus.in_valid ? S_PREP : S_IDLE;
        S_PREP:  state_s = special_s ? S_DONE : S_ITER;
        S_ITER:  state_s = (cnt_r == CW'(1)) ? S_POST : S_ITER;
        S_POST:  state_s = S_DONE;
        S_DONE:  state_s = (out_valid_r && bus.out_ready) ? S_IDLE : S_DONE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Output decode: out_valid follows DONE by one cycle and drops on handshake or flush
  always_comb begin
    in_ready_s     = (state_r == S_IDLE) && resetn;
    out_valid_nx_s = (state_r == S_DONE) && !bus.flush && !(out_valid_r && bus.out_ready);
  end

  // Registered result-valid flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nx_s;
    end
  end

  // Datapath: operand capture, iteration registers and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
      word_r   <= 1'b0;
      dvd_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      prem_r   <= {(WIDTH+1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      quot_r   <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            signed_r <= bus.is_signed;
            word_r   <= bus.is_word;
          end
        end
        S_PREP: begin
          if (b_zero_s) begin
            quot_r <= {WIDTH{1'b1}};
            rem_r  <= word_r ? sext_half(a_r) : a_r;
          end else if (ovf_s) begin
            quot_r <= min_s;
            rem_r  <= {WIDTH{1'b0}};
          end else if (early_s) begin
            quot_r <= {WIDTH{1'b0}};
            rem_r  <= word_r ? sext_half(a_r) : a_r;
          end else begin
            // word operands are left-aligned so the iteration always starts at bit WIDTH-1
            dvd_r  <= word_r ? {mag_a_s[HALF-1:0], {HALF{1'b0}}} : mag_a_s;
            dvs_r  <= mag_b_s;
            prem_r <= {(WIDTH+1){1'b0}};
            cnt_r  <= word_r ? CW'(NWORD) : CW'(NFULL);
          end
        end
        S_ITER: begin
          prem_r <= prem_nx_s;
          dvd_r  <= dvd_nx_s;
          cnt_r  <= cnt_r - CW'(1);
        end
        S_POST: begin
          quot_r <= q_fin_s;
          rem_r  <= r_fin_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.quot      = quot_r;
  assign bus.rem       = rem_r;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (WIDTH=64, STEP=1); expected values are hand-computed.
module tb_div_unit;
  localparam int W = 64;
`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_EARLY = 2;
`else
  localparam int LAT_EARLY = 67;
`endif

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .STEP(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operation, measure latency, optionally stall the result, then take it.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sg, input logic wd, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input int elat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "/in_ready"}, W'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = sg;
    bus.is_word   = wd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.b        = 64'h0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "/lat"}, W'(lat), W'(elat));
    chk({tag, "/quot"}, bus.quot, eq);
    chk({tag, "/rem"}, bus.rem, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "/hold_valid"}, W'(bus.out_valid), 64'd1);
      chk({tag, "/hold_quot"}, bus.quot, eq);
      chk({tag, "/hold_rem"}, bus.rem, er);
      chk({tag, "/hold_in_ready"}, W'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "/valid_drop"}, W'(bus.out_valid), 64'd0);
    chk({tag, "/ready_back"}, W'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 64'h0;
    bus.b         = 64'h0;
    bus.is_signed = 1'b0;
    bus.is_word   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/out_valid", W'(bus.out_valid), 64'd0);
    chk("rst/quot", bus.quot, 64'd0);
    chk("rst/rem", bus.rem, 64'd0);
    chk("rst/in_ready", W'(bus.in_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst/in_ready_rel", W'(bus.in_ready), 64'd1);

    run_op("udiv", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 67, 0);
    run_op("sdiv_neg_a", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run_op("sdiv_neg_b", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 67, 0);
    run_op("div_zero", 64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2, 0);
    run_op("sovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
           64'h8000_0000_0000_0000, 64'd0, 2, 0);
    run_op("w_sovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 2, 0);
    run_op("w_udiv", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 35, 0);
    run_op("w_sdiv", 64'hABCD_0000_FFFF_FFF9, 64'h1111_0000_0000_0002, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
    run_op("stall", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 67, 5);

    // flush together with in_valid in IDLE must not start an operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.a        = 64'd50;
    bus.b        = 64'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    chk("flush_vs_accept", W'(seen), 64'd0);

    // flush 10 cycles into an operation
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = 64'd100;
    bus.b         = 64'd7;
    bus.is_signed = 1'b0;
    bus.is_word   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush/out_valid", W'(bus.out_valid), 64'd0);
    chk("flush/in_ready", W'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("flush/no_result", W'(seen), 64'd0);
    run_op("after_flush", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 67, 0);

    // asynchronous reset in the middle of an iteration
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 64'd1000;
    bus.b        = 64'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst/out_valid", W'(bus.out_valid), 64'd0);
    chk("mid_rst/quot", bus.quot, 64'd0);
    chk("mid_rst/rem", bus.rem, 64'd0);
    chk("mid_rst/in_ready", W'(bus.in_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("early", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, LAT_EARLY, 0);
    run_op("udiv_again", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 67, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
